matrix_cmd_sched: RTL
=====================

# matrix_cmd_sched

Command scheduler in front of the matrix unit. It buffers geometry commands (op, code, object number) from the instruction decoder in a small FIFO and issues them one at a time to the matrix unit's `go`/`gmt_op`/`gmt_code`/`obj_num_in` inputs. Each command is held stable for its whole execution. Issue is deferred while the display reader owns video memory (`reading`), or while a create would hit a full object memory.

## Interface
Parameters:
- DEPTH, 4 — FIFO entries; must be a power of 2, ≥2.

Ports (reset rst_n, asynchronous, active-low; clock clk):
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd_vld  in  1  decoder presents a command
- cmd_rdy  out  1  FIFO can accept; = !full && !flush
- cmd_op  in  4  geometry opcode (0x0–0x7, 0xF legal)
- cmd_code  in  4  opcode modifier (scale/rotate/translate code)
- cmd_obj  in  5  target object number
- flush  in  1  synchronous clear of queued (not in-flight) commands
- reading  in  1  display reader active; blocks issue
- obj_mem_full  in  1  object memory full; blocks issue of op 0x0
- mtx_busy  in  1  matrix unit busy (combinational from matrix)
- go  out  1  issue strobe to matrix unit
- gmt_op  out  4  held opcode
- gmt_code  out  4  held code
- obj_num  out  5  held object number
- cmd_drop  out  1  one-cycle pulse: illegal opcode rejected at input
- q_cnt  out  log2(DEPTH)+1  FIFO occupancy
- sched_busy  out  1  (state != S_IDLE) || q_cnt != 0

## Operation
- Enqueue when cmd_vld && cmd_rdy. The FIFO stores {op, code, obj}, 13 bits per entry, using wrapping read and write pointers plus a count.
- Illegal opcodes 0x8–0xE are accepted (cmd_rdy honoured) and not written. cmd_drop pulses in the cycle after acceptance.
- Hold registers drive gmt_op, gmt_code and obj_num. They load only on pop and are otherwise stable, including across the whole matrix execution.
- FSM states: S_IDLE, S_ISSUE, S_RUN.
  - S_IDLE: if q_cnt != 0, pop into the hold registers and go to S_ISSUE. Otherwise stay.
  - S_ISSUE: go = !reading && !(gmt_op == 0x0 && obj_mem_full). This is combinational. When go = 1, go to S_RUN; otherwise stay. There is no timeout.
  - S_RUN: go = 0. When mtx_busy == 0, the command is complete:
    - if q_cnt != 0, pop and go to S_ISSUE (back-to-back issue);
    - otherwise go to S_IDLE.
- Single-cycle matrix ops (0x1, 0x2, 0xF) return the matrix to idle immediately. S_RUN therefore lasts exactly one cycle for them.
- flush clears the pointers and count. It does not affect the hold registers or the FSM, so an in-flight or pending-issue command completes. While flush is high, cmd_rdy = 0 and no push occurs.
- Full: cmd_rdy = 0, and cmd_vld is ignored. Empty: no pop is attempted.
- Simultaneous push and pop: count is unchanged and both pointers advance. A push into an empty FIFO is visible to the FSM the next cycle; there is no bypass.

## Timing
- Reset values:
  - st = S_IDLE
  - go = 0, cmd_rdy = 1, cmd_drop = 0
  - gmt_op = 0, gmt_code = 0, obj_num = 0
  - q_cnt = 0, sched_busy = 0
- Reset mid-operation abandons the held command. The FIFO is emptied, and no go is produced until a new command is queued.
- Latency: command accepted at edge N into an empty FIFO and idle FSM → pop at edge N+1 → go high during cycle N+1..N+2 (if unblocked). The matrix samples it at edge N+2.
- go is high for exactly one cycle per command and never twice for the same held command.
- mtx_busy is sampled only in S_RUN. The 1 it shows in the issue cycle is ignored.
- The hold registers change only on the edge that leaves S_IDLE or S_RUN.

## Test plan
- Single translate: push {op=3, code=1, obj=5} into an empty FIFO with reading=0. Required: go pulses once, 2 cycles after the accept edge. gmt_op/gmt_code/obj_num stay 3/1/5 while mtx_busy is held high for 20 cycles. S_IDLE is reached the cycle after mtx_busy falls, with sched_busy = 0.
- Back-to-back and full: push 5 commands with DEPTH=4 while the matrix is busy.
  - cmd_rdy drops at q_cnt=4.
  - Issue order is preserved.
  - Consecutive deletes (op 1) issue every 2 cycles: go, then the RUN completion cycle.
- Reading block: hold reading=1 for 10 cycles with a command pending in S_ISSUE. Required: go = 0 throughout, then go asserts the same cycle reading falls.
- Create with full memory: op=0 with obj_mem_full=1. Required: go stays 0 indefinitely. Deassert full → go pulses. A queued op=1 behind it is not reordered.
- Illegal op and flush:
  - Push op=0xA → cmd_drop pulses, q_cnt unchanged.
  - Queue 3 commands, pulse flush during S_RUN → q_cnt = 0, and the in-flight command completes with its held values intact.
- Async reset in S_RUN with q_cnt=2: all outputs return to reset values immediately, and no go follows afterward.

Source files
------------

// File: rtl/matrix_cmd_sched.sv
// matrix_cmd_sched
// Buffers geometry commands from the instruction decoder in a small FIFO and
// issues them one at a time to the matrix unit. The issued command is held in
// the gmt_* / obj_num registers for the whole matrix execution.
//
// Ports:
//   clk, rst_n          system clock, asynchronous active-low reset
//   cmd_vld / cmd_rdy   decoder handshake; cmd_op/cmd_code/cmd_obj carry the command
//   flush               synchronous clear of queued (not in-flight) commands
//   reading             display reader owns video memory; blocks issue
//   obj_mem_full        object memory full; blocks issue of create (op 0x0)
//   mtx_busy            matrix unit busy, sampled only while a command runs
//   go                  one-cycle issue strobe to the matrix unit
//   gmt_op/gmt_code/obj_num  held command fields
//   cmd_drop            one-cycle pulse after an illegal opcode is accepted
//   q_cnt               FIFO occupancy
//   sched_busy          scheduler has a command queued, pending or running
module matrix_cmd_sched #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_vld,
    output logic                     cmd_rdy,
    input  logic [3:0]               cmd_op,
    input  logic [3:0]               cmd_code,
    input  logic [4:0]               cmd_obj,
    input  logic                     flush,
    input  logic                     reading,
    input  logic                     obj_mem_full,
    input  logic                     mtx_busy,
    output logic                     go,
    output logic [3:0]               gmt_op,
    output logic [3:0]               gmt_code,
    output logic [4:0]               obj_num,
    output logic                     cmd_drop,
    output logic [$clog2(DEPTH):0]   q_cnt,
    output logic                     sched_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RUN
    } state_t;

    state_t          state_q, state_d;
    logic [12:0]     mem_q [DEPTH];
    logic [AW-1:0]   wrPtr_q, rdPtr_q;
    logic [CW-1:0]   count_q;
    logic [3:0]      holdOp_q, holdCode_q;
    logic [4:0]      holdObj_q;
    logic            drop_q;

    logic            accept;
    logic            legalOp;
    logic            push;
    logic            pop;
    logic            issueOk;

    // Illegal opcodes (0x8-0xE) still complete the handshake but are never stored.
    assign legalOp = (cmd_op[3] == 1'b0) || (cmd_op == 4'hF);
    assign cmd_rdy = (count_q != FULL_CNT) && !flush;
    assign accept  = cmd_vld && cmd_rdy;
    assign push    = accept && legalOp;

    assign issueOk = !reading && !((holdOp_q == 4'h0) && obj_mem_full);

    // Next-state and issue logic. Pops only ever happen when leaving IDLE or a
    // completed RUN, so the hold registers cannot change mid-execution.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        go      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                go = issueOk;
                if (issueOk) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!mtx_busy) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Storage array carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= {cmd_op, cmd_code, cmd_obj};
        end
    end

    // Flush empties the queue but leaves the held command and FSM alone. A pop
    // in the same cycle still reads the old head before the pointers clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else if (flush) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holdOp_q   <= '0;
            holdCode_q <= '0;
            holdObj_q  <= '0;
        end else if (pop) begin
            {holdOp_q, holdCode_q, holdObj_q} <= mem_q[rdPtr_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= accept && !legalOp;
        end
    end

    assign gmt_op     = holdOp_q;
    assign gmt_code   = holdCode_q;
    assign obj_num    = holdObj_q;
    assign cmd_drop   = drop_q;
    assign q_cnt      = count_q;
    assign sched_busy = (state_q != S_IDLE) || (count_q != '0);

endmodule
